// File: rtl/fft8_mad_sched.sv
// Issue/drain sequencer driving cpx_mad across an in-place 8-point radix-2 DIT FFT (3 stages x 4 butterflies).
// Define FFT8_SCHED_INVERSE_EN to add the `inverse` input, which selects conjugate twiddles for a pass.
module fft8_mad_sched #(
    parameter int MAD_LAT = 2   // rd_en to cpx_mad result latency, legal range 1..8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hold,
`ifdef FFT8_SCHED_INVERSE_EN
    input  logic       inverse,
`endif
    output logic       busy,
    output logic       done,
    output logic [1:0] stage,
    output logic       rd_en,
    output logic [2:0] rd_addr_a,
    output logic [2:0] rd_addr_b,
    output logic [2:0] twiddle_index,
    output logic       wr_en,
    output logic [2:0] wr_addr_a,
    output logic [2:0] wr_addr_b
);

    localparam int ADDR_W = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr_a;
        logic [ADDR_W-1:0] addr_b;
    } wb_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_stage;
    logic [1:0]        w_stage_nxt;
    logic [1:0]        r_k;
    logic [1:0]        w_k_nxt;
    logic              w_issue;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_inflight;
    logic              w_drain_done;
    logic [ADDR_W-1:0] w_addr_a;
    logic [ADDR_W-1:0] w_addr_b;
    logic [ADDR_W-1:0] w_tw_fwd;
    logic [ADDR_W-1:0] w_tw;

    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr_a;
    logic [ADDR_W-1:0] r_rd_addr_b;
    logic [ADDR_W-1:0] r_twiddle;
    wb_t               r_dly [MAD_LAT];

    // A stage is drained once the only valid entry left is the write-back leaving the line this cycle.
    always_comb begin
        w_inflight = r_rd_en;
        for (int i = 0; i < MAD_LAT - 1; i++) begin
            w_inflight = w_inflight | r_dly[i].vld;
        end
        w_drain_done = (r_state == S_DRAIN) && r_dly[MAD_LAT-1].vld && !w_inflight;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_ISSUE;
            S_ISSUE:  if (!hold && (r_k == 2'd3)) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (w_drain_done) w_state_nxt = (r_stage == 2'd2) ? S_FINISH : S_ISSUE;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so that the registered strobes line up with it.
    always_comb begin
        w_issue     = 1'b0;
        w_stage_nxt = r_stage;
        case (r_state)
            S_IDLE: begin
                w_stage_nxt = 2'd0;
                w_issue     = start && !hold;
            end
            S_ISSUE: w_issue = !hold;
            S_DRAIN: begin
                if (w_drain_done && (r_stage != 2'd2)) begin
                    w_stage_nxt = r_stage + 2'd1;
                    w_issue     = !hold;
                end
            end
            S_FINISH: w_stage_nxt = 2'd0;
            default:  w_stage_nxt = 2'd0;
        endcase
        // k wraps 3 -> 0 on the last issue, so it is already cleared for the next stage or pass.
        w_k_nxt    = w_issue ? (r_k + 2'd1) : r_k;
        w_busy_nxt = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_DRAIN);
        w_done_nxt = (w_state_nxt == S_FINISH);
    end

    // Butterfly k of stage s: pairs are span = 2^s apart, twiddle = pos << (2 - s).
    always_comb begin
        w_addr_a = '0;
        w_addr_b = '0;
        w_tw_fwd = '0;
        case (w_stage_nxt)
            2'd0: begin
                w_addr_a = {r_k, 1'b0};
                w_addr_b = {r_k, 1'b1};
            end
            2'd1: begin
                w_addr_a = {r_k[1], 1'b0, r_k[0]};
                w_addr_b = {r_k[1], 1'b1, r_k[0]};
                w_tw_fwd = {1'b0, r_k[0], 1'b0};
            end
            2'd2: begin
                w_addr_a = {1'b0, r_k};
                w_addr_b = {1'b1, r_k};
                w_tw_fwd = {1'b0, r_k};
            end
            default: begin
                w_addr_a = '0;
                w_addr_b = '0;
                w_tw_fwd = '0;
            end
        endcase
    end

`ifdef FFT8_SCHED_INVERSE_EN
    logic r_inv;
    logic w_inv_nxt;

    always_comb begin
        w_inv_nxt = r_inv;
        if ((r_state == S_IDLE) && start) w_inv_nxt = inverse;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_inv <= 1'b0;
        else        r_inv <= w_inv_nxt;
    end

    // Conjugate twiddle W8^-n is index (8 - n) mod 8.
    assign w_tw = w_inv_nxt ? (3'd0 - w_tw_fwd) : w_tw_fwd;
`else
    assign w_tw = w_tw_fwd;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage     <= 2'd0;
            r_k         <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_twiddle   <= '0;
            // NOTE: the write-back line is reset entry by entry so an aborted pass leaves no write pending.
            for (int i = 0; i < MAD_LAT; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_stage     <= w_stage_nxt;
            r_k         <= w_k_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_rd_en     <= w_issue;
            r_rd_addr_a <= w_issue ? w_addr_a : '0;
            r_rd_addr_b <= w_issue ? w_addr_b : '0;
            r_twiddle   <= w_issue ? w_tw : '0;
            // The line shifts every cycle regardless of hold, so issued butterflies always retire.
            r_dly[0]    <= '{vld: r_rd_en, addr_a: r_rd_addr_a, addr_b: r_rd_addr_b};
            for (int i = 1; i < MAD_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign stage         = r_stage;
    assign rd_en         = r_rd_en;
    assign rd_addr_a     = r_rd_addr_a;
    assign rd_addr_b     = r_rd_addr_b;
    assign twiddle_index = r_twiddle;
    assign wr_en         = r_dly[MAD_LAT-1].vld;
    assign wr_addr_a     = r_dly[MAD_LAT-1].addr_a;
    assign wr_addr_b     = r_dly[MAD_LAT-1].addr_b;

endmodule

// File: doc/fft8_mad_sched.md
Name: fft8_mad_sched

Overview:
- Sequencer for the `cpx_mad` complex multiply-add datapath across a full in-place 8-point radix-2 DIT FFT: 3 stages × 4 butterflies.
- Generates operand read addresses, `twiddle_index`, delayed write-back addresses and enables for the sample RAM.
- Tracks `cpx_mad` pipeline latency and drains between stages, so each stage reads only the completed results of the previous one.
- Sits between the top-level FFT control (start/done) and the sample RAM plus `cpx_mad`.

Parameters:
- MAD_LAT, 2, cycles from `rd_en` (operands presented) to valid `cpx_mad` result; legal range 1..8.
- ADDR_W, 3, sample address width (fixed for 8 points; not to be overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one FFT pass; sampled only in IDLE.
- hold  in  1  pauses butterfly issue; in-flight write-backs still complete.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse, pass complete.
- stage  out  2  current stage, 0..2.
- rd_en  out  1  operand read / `cpx_mad` issue strobe.
- rd_addr_a  out  3  butterfly top operand address.
- rd_addr_b  out  3  butterfly bottom operand address.
- twiddle_index  out  3  W8^n index to `cpx_mad`, valid with `rd_en`.
- wr_en  out  1  write-back strobe, exactly MAD_LAT cycles after the matching `rd_en`.
- wr_addr_a  out  3  write address for the top result.
- wr_addr_b  out  3  write address for the bottom result.

Behaviour:
- **Reset:**
  - `rst_n` low asynchronously clears the FSM to IDLE.
  - All outputs go to 0, counters go to 0, the write-back delay line is flushed.
  - Reset mid-pass abandons the pass: no further `wr_en`, no `done`.
- **Registers:** all outputs are registered.
- **FSM states:** IDLE, ISSUE, DRAIN, FINISH.
  - IDLE: `start`=1 → ISSUE next cycle, with `stage`=0 and k=0.
  - ISSUE: each cycle with `hold`=0:
    - assert `rd_en` with addresses and twiddle for butterfly k;
    - k increments;
    - after k=3 is issued → DRAIN.
  - ISSUE with `hold`=1: `rd_en`=0 and k holds.
  - DRAIN: wait until the `wr_en` of the stage's last butterfly has been emitted.
    - Then if `stage`<2: `stage`+1, k=0, ISSUE on the next cycle.
    - Otherwise → FINISH.
  - FINISH: `done`=1 and `busy`=0 for one cycle, then IDLE.
- **Start handling:**
  - `start` while not in IDLE is ignored; no queuing.
  - `start` in the FINISH cycle is also ignored.
- **Address/twiddle generation**, with span = 1<<stage, grp = k>>stage, pos = k & (span-1):
  - `rd_addr_a` = (grp << (stage+1)) + pos.
  - `rd_addr_b` = `rd_addr_a` + span.
  - `twiddle_index` = pos << (2-stage).
- **Write-back:** a MAD_LAT-deep shift register carries {valid, addr_a, addr_b}. It shifts every cycle, independent of `hold`. `wr_addr_a`/`wr_addr_b` equal the `rd_addr_a`/`rd_addr_b` issued MAD_LAT cycles earlier.
- **Timing, no hold:**
  - Each stage takes 4+MAD_LAT cycles.
  - The first issue of stage s+1 occurs in the cycle after the last `wr_en` of stage s.
  - With `start` accepted in cycle 0: `rd_en` first high in cycle 1, last `wr_en` in cycle 3·(4+MAD_LAT), `done` in the following cycle.
- **Hold during DRAIN:** no effect.

Optional Feature:
- Macro: FFT8_SCHED_INVERSE_EN.
- When defined:
  - adds input port `inverse` (1 bit), sampled and latched when `start` is accepted;
  - when latched 1, `twiddle_index` = (8 − fwd_index) & 7, i.e. the conjugate twiddle;
  - addresses and timing are unchanged.
- When undefined: no port, forward twiddles only.

Test Plan:
- **Forward sequence, no hold:** reset, then `start` pulse with MAD_LAT=2 → {a,b,tw} per `rd_en`:
  - stage 0: (0,1,0)(2,3,0)(4,5,0)(6,7,0);
  - stage 1: (0,2,0)(1,3,2)(4,6,0)(5,7,2);
  - stage 2: (0,4,0)(1,5,1)(2,6,2)(3,7,3);
  - `done` in cycle 19; 12 `rd_en` and 12 `wr_en` total.
- **Write-back delay and drain:** each `wr_en` is exactly 2 cycles after its `rd_en` with the same addresses. No stage-1 `rd_en` before the stage-0 `wr_en` for (6,7) has been seen.
- **Hold:** `hold`=1 for 3 cycles after the 2nd issue of stage 1 → 3-cycle gap in `rd_en`, in-flight `wr_en` still emitted, `done` delayed by exactly 3 cycles (cycle 22).
- **Start while busy / in FINISH:** extra `start` pulses mid-pass and in the `done` cycle → ignored, single `done`. A new `start` in IDLE afterwards runs a full pass.
- **Async reset mid-pass:** `rst_n` low during stage 1 DRAIN → outputs 0 immediately, no `wr_en`/`done` follows. Next `start` restarts from stage 0, (0,1,0).
- **FFT8_SCHED_INVERSE_EN with `inverse`=1:** stage 2 twiddles are 0,7,6,5; stage 1 twiddles are 0,6,0,6; addresses identical to the forward run.
